// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: clear PE array, feed K operand slices, drain, write N result rows, pulse done.
// Optional sticky PE-overflow flag (ovf_o) is built only when MATMUL_CTRL_OVF_EN is defined.
module matmul_ctrl #(
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [$clog2(MAX_DIM)-1:0]             n_dim_i,
    input  logic [$clog2(MAX_DIM)-1:0]             k_dim_i,
    input  logic [$clog2(MAX_DIM)-1:0]             m_dim_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]         sp_target_i,
    input  logic                                   pe_ovf_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   pe_clear_o,
    output logic                                   ops_rd_en_o,
    output logic [$clog2(MAX_DIM)-1:0]             ops_rd_addr_o,
    output logic                                   sp_we_o,
    output logic [$clog2(SP_NTARGETS*MAX_DIM)-1:0] sp_addr_o,
    output logic [$clog2(MAX_DIM)-1:0]             row_sel_o,
    output logic                                   ovf_o
);
    localparam int DW = $clog2(MAX_DIM);
    localparam int TW = $clog2(SP_NTARGETS);
    localparam int CW = $clog2(2*MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   n_q, k_q, m_q;
    logic [TW-1:0]   tgt_q;
    logic            accept;
    logic [CW-1:0]   feed_last, flush_last, write_last;

    assign accept = (state_q == S_IDLE) && start_i;

    // Counter terminal values: dims are stored minus one, so FLUSH (N+M-1 cycles) ends at n+m.
    assign feed_last  = CW'(k_q);
    assign flush_last = CW'(n_q) + CW'(m_q);
    assign write_last = CW'(n_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q   <= '0;
            k_q   <= '0;
            m_q   <= '0;
            tgt_q <= '0;
        end else if (accept) begin
            n_q   <= n_dim_i;
            k_q   <= k_dim_i;
            m_q   <= m_dim_i;
            tgt_q <= sp_target_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cnt_q == feed_last) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == flush_last) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt_q == write_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode the registered state only; indices are forced to zero when idle.
    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_o        = (state_q == S_DONE);
        pe_clear_o    = (state_q == S_CLEAR);
        ops_rd_en_o   = (state_q == S_FEED);
        sp_we_o       = (state_q == S_WRITE);
        ops_rd_addr_o = '0;
        row_sel_o     = '0;
        sp_addr_o     = '0;
        if (state_q == S_FEED) begin
            ops_rd_addr_o = cnt_q[DW-1:0];
        end
        if (state_q == S_WRITE) begin
            row_sel_o = cnt_q[DW-1:0];
            sp_addr_o = {tgt_q, cnt_q[DW-1:0]};
        end
    end

`ifdef MATMUL_CTRL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_CLEAR) begin
            ovf_q <= 1'b0;
        end else if (pe_ovf_i && ((state_q == S_FEED) || (state_q == S_FLUSH))) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic pe_ovf_unused;

    assign pe_ovf_unused = pe_ovf_i;
    assign ovf_o         = 1'b0;
`endif

endmodule
